// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, loader FSM state type and index-width helper.
// Imported by fft_sample_loader and addr_bit_reverse.
package fft_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } loader_state_t;

    // Smallest r with 2**r >= n.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addr_bit_reverse.sv
// addr_bit_reverse: combinational reversal of a W-bit index.
// Ports: idx_i (natural index), idx_o (bit-reversed index).
module addr_bit_reverse #(
    parameter int W = 10
) (
    input  logic [W-1:0] idx_i,
    output logic [W-1:0] idx_o
);
    import fft_pkg::*;

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < W; i++) begin
            idx_o[i] = idx_i[W-1-i];
        end
    end

endmodule

// File: rtl/fft_sample_loader.sv
// fft_sample_loader: reads NUM_SAMPLES words from the file interface and
// re-issues them on a valid/ready stream tagged with their FFT buffer index.
// Ports: clk, n_rst (async active-low), start; file_read_enable,
// file_address, file_data (file side); out_valid, out_ready, out_data,
// out_addr (stream side); busy, done (status).
// Build option: define FFT_SAMPLE_LOADER_BITREV_EN for bit-reversed out_addr.
module fft_sample_loader #(
    parameter int ADDR_W      = fft_pkg::ADDR_W,
    parameter int DATA_W      = fft_pkg::DATA_W,
    parameter int NUM_SAMPLES = 1024
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              file_read_enable,
    output logic [ADDR_W-1:0] file_address,
    input  logic [DATA_W-1:0] file_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);
    import fft_pkg::*;

    localparam int IDX_RAW = log2(NUM_SAMPLES);
    localparam int IDX_W   = (IDX_RAW < 1) ? 1 : IDX_RAW;

    loader_state_t     state_q;
    logic [ADDR_W-1:0] count_q;
    logic              rd_en_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;
    logic              done_q;

    logic [IDX_W-1:0]  idx_nat;
    logic [IDX_W-1:0]  idx_map;
    logic [ADDR_W-1:0] idx_ext;
    logic              last;

    assign idx_nat = count_q[IDX_W-1:0];

`ifdef FFT_SAMPLE_LOADER_BITREV_EN
    addr_bit_reverse #(
        .W (IDX_W)
    ) u_rev (
        .idx_i (idx_nat),
        .idx_o (idx_map)
    );
`else
    assign idx_map = idx_nat;
`endif

    assign idx_ext = ADDR_W'(idx_map);
    assign last    = (count_q == ADDR_W'(NUM_SAMPLES - 1));

    // Every output is a register, so an async reset clears them at once.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= FETCH;
                        count_q <= '0;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    data_q  <= file_data;
                    addr_q  <= idx_ext;
                    valid_q <= 1'b1;
                    rd_en_q <= 1'b0;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                            rd_en_q <= 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    count_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign file_read_enable = rd_en_q;
    assign file_address     = count_q;
    assign out_valid        = valid_q;
    assign out_data         = data_q;
    assign out_addr         = addr_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// tb_fft_sample_loader: randomized scoreboard bench for fft_sample_loader.
// Honours FFT_SAMPLE_LOADER_BITREV_EN in its reference index model.
module tb_fft_sample_loader;

    localparam int N  = 8;
    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          file_read_enable;
    logic [AW-1:0] file_address;
    logic [DW-1:0] file_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_chk  = 0;
    int n_fail = 0;

    assign file_data = mem[file_address];

    always #5 clk = ~clk;

    fft_sample_loader #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .NUM_SAMPLES (N)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .start            (start),
        .file_read_enable (file_read_enable),
        .file_address     (file_address),
        .file_data        (file_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_addr         (out_addr),
        .busy             (busy),
        .done             (done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Destination index: reverse the log2(N) low bits when enabled.
    function automatic int idx_of(input int k);
`ifdef FFT_SAMPLE_LOADER_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; (1 << b) < N; b++) begin
            if ((k >> b) % 2 == 1) begin
                r = r + ((N / 2) >> b);
            end
        end
        return r;
`else
        return k;
`endif
    endfunction

    // mode 0: ready high, 1: random ready, 2: stall 5 cycles on stall_idx
    task automatic run_frame(input int mode, input int stall_idx,
                             input int start_at, input bit chk_len);
        int k, dones, cyc, t0, t1, stall, after;
        bit pulsed, stalled;
        logic [DW-1:0] held_d;
        logic [AW-1:0] held_a;
        k = 0; dones = 0; cyc = 0; t0 = -1; t1 = -1;
        stall = 0; after = 0; pulsed = 0; stalled = 0;
        held_d = '0; held_a = '0;
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (cyc < 600 && !(dones > 0 && after >= 3)) begin
            @(negedge clk);
            cyc++;
            if (busy && t0 < 0) t0 = cyc;
            chk("rd_and_valid", 32'(file_read_enable & out_valid), 0);
            if (file_read_enable)
                chk("fetch_addr", 32'(file_address), 32'(k));
            if (out_valid && !out_ready) begin
                if (stalled) begin
                    chk("hold_data", 32'(out_data), 32'(held_d));
                    chk("hold_addr", 32'(out_addr), 32'(held_a));
                end
                stalled = 1;
                held_d = out_data;
                held_a = out_addr;
                if (mode == 2) begin
                    chk("stall_data", 32'(out_data), 32'(mem[stall_idx]));
                    chk("stall_rd", 32'(file_read_enable), 0);
                end
            end else begin
                stalled = 0;
            end
            if (out_valid && out_ready) begin
                if (k < N) begin
                    chk("acc_addr", 32'(out_addr), 32'(idx_of(k)));
                    chk("acc_data", 32'(out_data), 32'(mem[k]));
                end
                k++;
            end
            if (done) begin
                dones++;
                t1 = cyc;
            end
            if (dones > 0) after++;
            @(posedge clk); #1;
            start = 1'b0;
            if (start_at >= 0 && !pulsed && out_valid && k == start_at) begin
                start = 1'b1;
                pulsed = 1;
            end
            if (mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else if (mode == 2 && out_valid && k == stall_idx
                         && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
            end
        end
        start = 1'b0;
        chk("n_accept", 32'(k), 32'(N));
        chk("n_done", 32'(dones), 1);
        if (chk_len) chk("frame_len", 32'(t1 - t0 + 1), 32'(2 * N + 1));
        if (mode == 2) chk("stall_cycles", 32'(stall), 5);
    endtask

    task automatic reset_mid_frame();
        int w;
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd", 32'(file_read_enable), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        for (int i = 0; i < N; i++) mem[i] = DW'(16'h41 + 2 * i);
        #1;
        chk("reset_rd", 32'(file_read_enable), 0);
        chk("reset_faddr", 32'(file_address), 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_data", 32'(out_data), 0);
        chk("reset_addr", 32'(out_addr), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        #11;
        n_rst = 1'b1;
        run_frame(0, -1, -1, 1'b1);
        run_frame(2, 2, -1, 1'b0);
        run_frame(0, -1, 4, 1'b1);
        reset_mid_frame();
        run_frame(0, -1, -1, 1'b1);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
            run_frame(1, -1, -1, 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
